// File: rtl/axi_tlb_l1_lookup.sv
// axi_tlb_l1_lookup: fully-associative 4 KiB-page L1 TLB with independent registered AW/AR lookup channels.
module axi_tlb_l1_lookup #(
  parameter int unsigned InpAddrWidth = 32,
  parameter int unsigned OupAddrWidth = 32,
  parameter int unsigned NumEntries   = 4,
  parameter int unsigned IdxWidth     = (NumEntries > 1) ? $clog2(NumEntries) : 1
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [InpAddrWidth-1:0]  wr_req_addr_i,
  input  logic                     wr_req_valid_i,
  output logic                     wr_req_ready_o,
  output logic                     wr_res_hit_o,
  output logic [OupAddrWidth-1:0]  wr_res_addr_o,
  output logic                     wr_res_valid_o,
  input  logic                     wr_res_ready_i,
  input  logic [InpAddrWidth-1:0]  rd_req_addr_i,
  input  logic                     rd_req_valid_i,
  output logic                     rd_req_ready_o,
  output logic                     rd_res_hit_o,
  output logic [OupAddrWidth-1:0]  rd_res_addr_o,
  output logic                     rd_res_valid_o,
  input  logic                     rd_res_ready_i,
  input  logic                     cfg_we_i,
  input  logic [IdxWidth-1:0]      cfg_idx_i,
  input  logic [InpAddrWidth-13:0] cfg_first_i,
  input  logic [InpAddrWidth-13:0] cfg_last_i,
  input  logic [OupAddrWidth-13:0] cfg_base_i,
  input  logic                     cfg_valid_i,
  input  logic                     cfg_ro_i,
  input  logic                     cfg_flush_i
);
  localparam int unsigned InpPageW = InpAddrWidth - 12;
  localparam int unsigned OupPageW = OupAddrWidth - 12;

  logic [InpPageW-1:0] r_first [NumEntries];
  logic [InpPageW-1:0] r_last  [NumEntries];
  logic [OupPageW-1:0] r_base  [NumEntries];
  logic [NumEntries-1:0] r_valid, r_ro;

  logic                    r_wr_valid, r_wr_hit, r_rd_valid, r_rd_hit;
  logic [OupAddrWidth-1:0] r_wr_addr, r_rd_addr;
  logic [OupAddrWidth:0]   w_wr_lu, w_rd_lu;
  logic                    w_wr_acc, w_rd_acc;

  // Descending scan so the lowest matching index is the last assignment and wins.
  function automatic logic [OupAddrWidth:0] lookup(input logic [InpAddrWidth-1:0] a, input logic wr);
    logic [InpPageW-1:0]          pg, diff;
    logic [InpPageW+OupPageW-1:0] ext;
    lookup = '0;
    pg = a[InpAddrWidth-1:12];
    for (int i = NumEntries - 1; i >= 0; i--) begin
      diff = pg - r_first[i];
      ext  = {{OupPageW{1'b0}}, diff};
      if (r_valid[i] && !(wr && r_ro[i]) && r_first[i] <= pg && pg <= r_last[i])
        lookup = {1'b1, r_base[i] + ext[OupPageW-1:0], a[11:0]};
    end
  endfunction

  assign w_wr_lu        = lookup(wr_req_addr_i, 1'b1);
  assign w_rd_lu        = lookup(rd_req_addr_i, 1'b0);
  assign wr_req_ready_o = !r_wr_valid || wr_res_ready_i;
  assign rd_req_ready_o = !r_rd_valid || rd_res_ready_i;
  assign w_wr_acc       = wr_req_valid_i && wr_req_ready_o;
  assign w_rd_acc       = rd_req_valid_i && rd_req_ready_o;
  assign wr_res_valid_o = r_wr_valid;
  assign wr_res_hit_o   = r_wr_hit;
  assign wr_res_addr_o  = r_wr_addr;
  assign rd_res_valid_o = r_rd_valid;
  assign rd_res_hit_o   = r_rd_hit;
  assign rd_res_addr_o  = r_rd_addr;

  // Flush is applied first so a simultaneous write still lands.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_valid <= '0;
      r_ro    <= '0;
      for (int i = 0; i < NumEntries; i++) begin
        r_first[i] <= '0;
        r_last[i]  <= '0;
        r_base[i]  <= '0;
      end
    end else begin
      if (cfg_flush_i) r_valid <= '0;
      for (int i = 0; i < NumEntries; i++) begin
        if (cfg_we_i && cfg_idx_i == IdxWidth'(i)) begin
          r_first[i] <= cfg_first_i;
          r_last[i]  <= cfg_last_i;
          r_base[i]  <= cfg_base_i;
          r_valid[i] <= cfg_valid_i;
          r_ro[i]    <= cfg_ro_i;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wr_valid <= 1'b0;
      r_wr_hit   <= 1'b0;
      r_wr_addr  <= '0;
    end else if (w_wr_acc) begin
      r_wr_valid <= 1'b1;
      r_wr_hit   <= w_wr_lu[OupAddrWidth];
      r_wr_addr  <= w_wr_lu[OupAddrWidth-1:0];
    end else if (wr_res_ready_i) begin
      r_wr_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rd_valid <= 1'b0;
      r_rd_hit   <= 1'b0;
      r_rd_addr  <= '0;
    end else if (w_rd_acc) begin
      r_rd_valid <= 1'b1;
      r_rd_hit   <= w_rd_lu[OupAddrWidth];
      r_rd_addr  <= w_rd_lu[OupAddrWidth-1:0];
    end else if (rd_res_ready_i) begin
      r_rd_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_axi_tlb_l1_lookup.sv
// tb_axi_tlb_l1_lookup: directed and randomized checks of the L1 TLB against a page-range reference model.
module tb_axi_tlb_l1_lookup;
  localparam int NE = 5;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic [31:0] wr_req_addr_i, rd_req_addr_i, wr_res_addr_o, rd_res_addr_o;
  logic        wr_req_valid_i, wr_req_ready_o, wr_res_hit_o, wr_res_valid_o, wr_res_ready_i;
  logic        rd_req_valid_i, rd_req_ready_o, rd_res_hit_o, rd_res_valid_o, rd_res_ready_i;
  logic        cfg_we_i, cfg_valid_i, cfg_ro_i, cfg_flush_i;
  logic [2:0]  cfg_idx_i;
  logic [19:0] cfg_first_i, cfg_last_i, cfg_base_i;

  int checks = 0;
  int failures = 0;

  bit          m_v [NE];
  bit          m_ro [NE];
  int unsigned m_first [NE], m_last [NE], m_base [NE];
  bit          ew_v, ew_h, er_v, er_h;
  logic [31:0] ew_a, er_a;

  axi_tlb_l1_lookup #(.InpAddrWidth(32), .OupAddrWidth(32), .NumEntries(NE)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .wr_req_addr_i(wr_req_addr_i), .wr_req_valid_i(wr_req_valid_i), .wr_req_ready_o(wr_req_ready_o),
    .wr_res_hit_o(wr_res_hit_o), .wr_res_addr_o(wr_res_addr_o), .wr_res_valid_o(wr_res_valid_o),
    .wr_res_ready_i(wr_res_ready_i),
    .rd_req_addr_i(rd_req_addr_i), .rd_req_valid_i(rd_req_valid_i), .rd_req_ready_o(rd_req_ready_o),
    .rd_res_hit_o(rd_res_hit_o), .rd_res_addr_o(rd_res_addr_o), .rd_res_valid_o(rd_res_valid_o),
    .rd_res_ready_i(rd_res_ready_i),
    .cfg_we_i(cfg_we_i), .cfg_idx_i(cfg_idx_i), .cfg_first_i(cfg_first_i), .cfg_last_i(cfg_last_i),
    .cfg_base_i(cfg_base_i), .cfg_valid_i(cfg_valid_i), .cfg_ro_i(cfg_ro_i), .cfg_flush_i(cfg_flush_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk1(string tag, logic o, logic e);
    checks++;
    assert (o === e) else begin
      failures++;
      $error("FAIL %s obs=%0h exp=%0h", tag, o, e);
    end
  endtask

  task automatic chka(string tag, logic [31:0] o, logic [31:0] e);
    checks++;
    assert (o === e) else begin
      failures++;
      $error("FAIL %s obs=%08h exp=%08h", tag, o, e);
    end
  endtask

  // Reference translation: scan entries in index order, first hit wins.
  function automatic logic [32:0] mlook(logic [31:0] a, bit wr);
    int unsigned pg;
    pg = int'(a >> 12);
    for (int i = 0; i < NE; i++)
      if (m_v[i] && !(wr && m_ro[i]) && m_first[i] <= pg && pg <= m_last[i])
        return {1'b1, (((m_base[i] + pg - m_first[i]) & 32'hFFFFF) << 12) | (a & 32'hFFF)};
    return 33'd0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NE; i++) begin
      m_v[i] = 0; m_ro[i] = 0; m_first[i] = 0; m_last[i] = 0; m_base[i] = 0;
    end
    ew_v = 0; ew_h = 0; ew_a = 0; er_v = 0; er_h = 0; er_a = 0;
  endtask

  // Called #1 after a rising edge with inputs set; advances one cycle and checks all outputs.
  task automatic tick();
    logic [32:0] lw, lr;
    bit aw, ar;
    #2;
    chk1("wr_ready", wr_req_ready_o, !ew_v || wr_res_ready_i);
    chk1("rd_ready", rd_req_ready_o, !er_v || rd_res_ready_i);
    aw = wr_req_valid_i && (!ew_v || wr_res_ready_i);
    ar = rd_req_valid_i && (!er_v || rd_res_ready_i);
    lw = mlook(wr_req_addr_i, 1);
    lr = mlook(rd_req_addr_i, 0);
    @(posedge clk_i);
    if (aw) begin ew_v = 1; ew_h = lw[32]; ew_a = lw[31:0]; end
    else if (wr_res_ready_i) ew_v = 0;
    if (ar) begin er_v = 1; er_h = lr[32]; er_a = lr[31:0]; end
    else if (rd_res_ready_i) er_v = 0;
    if (cfg_flush_i) for (int i = 0; i < NE; i++) m_v[i] = 0;
    if (cfg_we_i && int'(cfg_idx_i) < NE) begin
      m_first[int'(cfg_idx_i)] = 32'(cfg_first_i);
      m_last[int'(cfg_idx_i)]  = 32'(cfg_last_i);
      m_base[int'(cfg_idx_i)]  = 32'(cfg_base_i);
      m_v[int'(cfg_idx_i)]     = cfg_valid_i;
      m_ro[int'(cfg_idx_i)]    = cfg_ro_i;
    end
    #1;
    chk1("wr_valid", wr_res_valid_o, ew_v);
    chk1("wr_hit", wr_res_hit_o, ew_h);
    chka("wr_addr", wr_res_addr_o, ew_a);
    chk1("rd_valid", rd_res_valid_o, er_v);
    chk1("rd_hit", rd_res_hit_o, er_h);
    chka("rd_addr", rd_res_addr_o, er_a);
  endtask

  task automatic set_cfg(int idx, int unsigned f, int unsigned l, int unsigned b, bit v, bit ro);
    cfg_we_i = 1; cfg_idx_i = 3'(idx); cfg_first_i = 20'(f); cfg_last_i = 20'(l);
    cfg_base_i = 20'(b); cfg_valid_i = v; cfg_ro_i = ro;
  endtask

  task automatic cfg_write(int idx, int unsigned f, int unsigned l, int unsigned b, bit v, bit ro);
    set_cfg(idx, f, l, b, v, ro);
    tick();
    cfg_we_i = 0;
  endtask

  task automatic req(bit w, bit r, logic [31:0] a);
    wr_req_valid_i = w; rd_req_valid_i = r; wr_req_addr_i = a; rd_req_addr_i = a;
    tick();
    wr_req_valid_i = 0; rd_req_valid_i = 0;
  endtask

  initial begin
    rst_ni = 0; model_reset();
    wr_req_addr_i = 0; rd_req_addr_i = 0; wr_req_valid_i = 0; rd_req_valid_i = 0;
    wr_res_ready_i = 1; rd_res_ready_i = 1;
    cfg_we_i = 0; cfg_idx_i = 0; cfg_first_i = 0; cfg_last_i = 0; cfg_base_i = 0;
    cfg_valid_i = 0; cfg_ro_i = 0; cfg_flush_i = 0;
    repeat (2) @(posedge clk_i);
    #1;
    rst_ni = 1;
    chk1("rst_wr_valid", wr_res_valid_o, 1'b0);
    chk1("rst_rd_valid", rd_res_valid_o, 1'b0);
    chk1("rst_wr_hit", wr_res_hit_o, 1'b0);
    chka("rst_rd_addr", rd_res_addr_o, 32'h0);
    chk1("rst_wr_ready", wr_req_ready_o, 1'b1);

    req(1, 0, 32'h0000_5123);
    chk1("empty_valid", wr_res_valid_o, 1'b1);
    chk1("empty_hit", wr_res_hit_o, 1'b0);
    chka("empty_addr", wr_res_addr_o, 32'h0);
    tick();
    chk1("empty_drain", wr_res_valid_o, 1'b0);

    cfg_write(0, 'h10, 'h1F, 'h80, 1, 0);
    req(0, 1, 32'h0001_4ABC);
    chk1("e0_hit", rd_res_hit_o, 1'b1);
    chka("e0_addr", rd_res_addr_o, 32'h0008_4ABC);
    req(0, 1, 32'h0002_0000);
    chk1("e0_above", rd_res_hit_o, 1'b0);

    cfg_write(0, 'h10, 'h1F, 'h80, 1, 1);
    req(1, 1, 32'h0001_0000);
    chka("ro_rd_addr", rd_res_addr_o, 32'h0008_0000);
    chk1("ro_wr_hit", wr_res_hit_o, 1'b0);
    chka("ro_wr_addr", wr_res_addr_o, 32'h0);

    cfg_write(0, 0, 0, 0, 0, 0);
    cfg_write(1, 'h10, 'h10, 'h200, 1, 0);
    cfg_write(3, 'h00, 'hFF, 'h300, 1, 0);
    req(1, 1, 32'h0001_0004);
    chka("prio_rd", rd_res_addr_o, 32'h0020_0004);
    chka("prio_wr", wr_res_addr_o, 32'h0020_0004);
    req(0, 1, 32'h0002_0004);
    chka("e3_off", rd_res_addr_o, 32'h0032_0004);

    wr_res_ready_i = 0; wr_req_valid_i = 1;
    for (int i = 0; i < 5; i++) begin
      wr_req_addr_i = (i == 0) ? 32'h0001_0004 : 32'h0004_0000 + 32'(i);
      tick();
    end
    chka("hold_addr", wr_res_addr_o, 32'h0020_0004);
    #2 chk1("hold_ready", wr_req_ready_o, 1'b0);
    @(posedge clk_i); #1;
    ew_v = 1;
    wr_res_ready_i = 1;
    for (int i = 0; i < 4; i++) begin
      wr_req_addr_i = 32'h0002_0004 + 32'(i) * 32'h1000;
      tick();
      chka("b2b_addr", wr_res_addr_o, 32'h0032_0004 + 32'(i) * 32'h1000);
    end
    wr_req_valid_i = 0;
    tick();

    cfg_write(0, 'h10, 'h1F, 'h80, 1, 0);
    set_cfg(0, 'h10, 'h1F, 'h90, 1, 0);
    req(0, 1, 32'h0001_4ABC);
    cfg_we_i = 0;
    chka("same_cyc_old", rd_res_addr_o, 32'h0008_4ABC);
    req(0, 1, 32'h0001_4ABC);
    chka("same_cyc_new", rd_res_addr_o, 32'h0009_4ABC);

    cfg_write(6, 'h50, 'h50, 'h111, 1, 0);
    req(0, 1, 32'h0005_0000);
    chka("idx_oob", rd_res_addr_o, 32'h0035_0000);

    cfg_flush_i = 1; tick(); cfg_flush_i = 0;
    req(1, 1, 32'h0001_4ABC);
    chk1("flush_rd", rd_res_hit_o, 1'b0);
    chk1("flush_wr", wr_res_hit_o, 1'b0);

    cfg_flush_i = 1;
    cfg_write(2, 'h40, 'h40, 'h7, 1, 0);
    cfg_flush_i = 0;
    req(0, 1, 32'h0004_0001);
    chka("flush_we", rd_res_addr_o, 32'h0000_7001);

    for (int n = 0; n < 2000; n++) begin
      int unsigned f;
      wr_req_valid_i = $urandom_range(0, 3) != 0;
      rd_req_valid_i = $urandom_range(0, 3) != 0;
      wr_req_addr_i = {20'($urandom_range(0, 70)), 12'($urandom)};
      rd_req_addr_i = {20'($urandom_range(0, 70)), 12'($urandom)};
      wr_res_ready_i = $urandom_range(0, 3) != 0;
      rd_res_ready_i = $urandom_range(0, 3) != 0;
      cfg_flush_i = $urandom_range(0, 59) == 0;
      f = $urandom_range(0, 48);
      set_cfg(int'($urandom_range(0, 7)), f,
              ($urandom_range(0, 7) == 0 && f > 0) ? f - 1 : f + $urandom_range(0, 16),
              $urandom, $urandom_range(0, 7) != 0, $urandom_range(0, 3) == 0);
      cfg_we_i = $urandom_range(0, 7) == 0;
      tick();
    end
    cfg_we_i = 0; cfg_flush_i = 0;

    wr_res_ready_i = 0; rd_res_ready_i = 0;
    req(1, 1, 32'h0001_0000);
    rst_ni = 0;
    #1;
    model_reset();
    chk1("arst_wr_valid", wr_res_valid_o, 1'b0);
    chk1("arst_rd_valid", rd_res_valid_o, 1'b0);
    chka("arst_wr_addr", wr_res_addr_o, 32'h0);
    chk1("arst_rd_hit", rd_res_hit_o, 1'b0);
    @(posedge clk_i); #1;
    rst_ni = 1; wr_res_ready_i = 1; rd_res_ready_i = 1;
    req(1, 1, 32'h0001_0000);
    chk1("arst_entries", rd_res_hit_o, 1'b0);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
